// File: rtl/cp0_vic_if.sv
// Pipeline-side bus of the vectored interrupt coprocessor: register access,
// interrupt lines and the redirect request back to the fetch stage.
interface cp0_vic_if #(
  parameter int unsigned NUM_IRQ = 8
);
  logic [1:0]         oper;
  logic [4:0]         addr_r;
  logic [31:0]        data_r;
  logic [4:0]         addr_w;
  logic [31:0]        data_w;
  logic               ir_en;
  logic [NUM_IRQ-1:0] ir_in;
  logic [31:0]        ret_addr;
  logic               jump_en;
  logic [31:0]        jump_addr;

  modport master (
    output oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    input  data_r, jump_en, jump_addr
  );

  modport slave (
    input  oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    output data_r, jump_en, jump_addr
  );
endinterface

// File: rtl/cp0_vic.sv
// Vectored interrupt coprocessor: NUM_IRQ sticky external lines plus a
// COUNT/COMPARE timer source, with EPC/ERET redirect into the pipeline.
module cp0_vic #(
  parameter int unsigned NUM_IRQ   = 8,
  parameter int unsigned VEC_SHIFT = 4,
  parameter logic [31:0] EHBR_RST  = 32'h0
) (
  input logic       clk,
  input logic       rst,
  cp0_vic_if.slave  bus
);
  localparam int unsigned NS = NUM_IRQ + 1;

  localparam logic [1:0] OpNone  = 2'b00;
  localparam logic [1:0] OpStore = 2'b01;
  localparam logic [1:0] OpEret  = 2'b10;
  localparam logic [1:0] OpRsvd  = 2'b11;

  localparam logic [4:0] AddrCount   = 5'd9;
  localparam logic [4:0] AddrCompare = 5'd11;
  localparam logic [4:0] AddrStatus  = 5'd12;
  localparam logic [4:0] AddrCause   = 5'd13;
  localparam logic [4:0] AddrEpc     = 5'd14;
  localparam logic [4:0] AddrEhbr    = 5'd15;

  logic [31:0]   count_q, compare_q, epc_q, ehbr_q;
  logic          ie_q, exl_q, ve_q;
  logic [NS-1:0] mask_q, pend_q, pend_d;
  logic [4:0]    code_q;
  logic [1:0]    oper_prev_q;

  logic [NS-1:0] pend_mask, sel_onehot;
  logic [4:0]    sel;
  logic          req, ir, eret, wr, timer_hit;
  logic [31:0]   status_rd, cause_rd;

  assign pend_mask = pend_q & mask_q;
  assign req       = (|pend_mask) & ie_q & ~exl_q;
  assign ir        = bus.ir_en & req & ~rst;
  // Only the first cycle of a held ERET counts.
  assign eret      = (bus.oper == OpEret) && (oper_prev_q != OpEret) && !rst;
  assign wr        = (bus.oper == OpStore) && !ir;
  assign timer_hit = (count_q == compare_q) && (compare_q != 32'h0);

  // Lowest index wins, so scan downward and let the last hit stick.
  always_comb begin
    sel = 5'd0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (pend_mask[i]) sel = 5'(i);
    end
  end

  assign sel_onehot = NS'(1) << sel;

  always_comb begin
    bus.jump_en   = ir | eret;
    bus.jump_addr = 32'h0;
    if (ir) begin
      bus.jump_addr = ve_q ? ehbr_q + (32'(sel) << VEC_SHIFT) : ehbr_q;
    end else if (eret) begin
      bus.jump_addr = epc_q;
    end
  end

  always_comb begin
    status_rd             = 32'h0;
    status_rd[0]          = ie_q;
    status_rd[1]          = exl_q;
    status_rd[2]          = ve_q;
    status_rd[16 +: NS]   = mask_q;
    cause_rd              = 32'h0;
    cause_rd[NS-1:0]      = pend_q;
    cause_rd[28:24]       = code_q;
  end

  always_comb begin
    bus.data_r = 32'h0;
    if (bus.oper == OpNone || bus.oper == OpRsvd) begin
      unique case (bus.addr_r)
        AddrCount:   bus.data_r = count_q;
        AddrCompare: bus.data_r = compare_q;
        AddrStatus:  bus.data_r = status_rd;
        AddrCause:   bus.data_r = cause_rd;
        AddrEpc:     bus.data_r = epc_q;
        AddrEhbr:    bus.data_r = ehbr_q;
        default:     bus.data_r = 32'h0;
      endcase
    end
  end

  // Clears first, then sets, so a same-cycle set always survives.
  always_comb begin
    pend_d = pend_q;
    if (wr && bus.addr_w == AddrCause)   pend_d = pend_d & ~bus.data_w[NS-1:0];
    if (wr && bus.addr_w == AddrCompare) pend_d[NS-1] = 1'b0;
    if (ir)                              pend_d = pend_d & ~sel_onehot;
    pend_d = pend_d | {timer_hit, bus.ir_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 32'h0;
      compare_q   <= 32'h0;
      ie_q        <= 1'b0;
      exl_q       <= 1'b0;
      ve_q        <= 1'b0;
      mask_q      <= '0;
      pend_q      <= '0;
      code_q      <= 5'd0;
      epc_q       <= 32'h0;
      ehbr_q      <= EHBR_RST;
      oper_prev_q <= OpNone;
    end else begin
      oper_prev_q <= bus.oper;
      pend_q      <= pend_d;
      count_q     <= (wr && bus.addr_w == AddrCount) ? bus.data_w : count_q + 32'd1;
      if (wr && bus.addr_w == AddrCompare) compare_q <= bus.data_w;
      if (wr && bus.addr_w == AddrEhbr)    ehbr_q    <= bus.data_w;
      if (wr && bus.addr_w == AddrStatus) begin
        ie_q   <= bus.data_w[0];
        ve_q   <= bus.data_w[2];
        mask_q <= bus.data_w[16 +: NS];
      end
      if (ir) begin
        exl_q  <= 1'b1;
        epc_q  <= bus.ret_addr;
        code_q <= sel;
      end else begin
        if (eret) exl_q <= 1'b0;
        else if (wr && bus.addr_w == AddrStatus) exl_q <= bus.data_w[1];
        if (wr && bus.addr_w == AddrEpc) epc_q <= bus.data_w;
      end
    end
  end
endmodule

// File: tb/tb_cp0_vic.sv
// Directed bench for cp0_vic: reset, vectored entry, tail-chaining, timer,
// ERET edge detection, dropped MTC0 on entry and mid-handler reset.
module tb_cp0_vic;
  localparam int unsigned NIRQ     = 8;
  localparam logic [31:0] EHBR_RST = 32'hBFC0_0180;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   failures  = 0;

  always #5 clk = ~clk;

  cp0_vic_if #(.NUM_IRQ(NIRQ)) bus ();

  cp0_vic #(
    .NUM_IRQ  (NIRQ),
    .VEC_SHIFT(4),
    .EHBR_RST (EHBR_RST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.oper   = 2'b00;
    bus.addr_r = a;
    #1;
    d = bus.data_r;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.oper   = 2'b01;
    bus.addr_w = a;
    bus.data_w = d;
    @(negedge clk);
    bus.oper   = 2'b00;
  endtask

  task automatic pulse_irq(input logic [NIRQ-1:0] lines);
    bus.ir_in = lines;
    @(negedge clk);
    bus.ir_in = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        seen;
    seen = 1'b0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (bus.jump_en !== 1'b0) begin
      failures++; $display("FAIL rst_jump_en: got %b want 0", bus.jump_en);
    end
    rd(5'd9, d);
    tests_run++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL rst_count: got %h want 0", d);
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (bus.jump_en !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL idle_jump_en: got 1 want 0");
    end
    rd(5'd9, d);
    tests_run++;
    if (d !== 32'd10) begin
      failures++; $display("FAIL count_10: got %0d want 10", d);
    end
    rd(5'd15, d);
    tests_run++;
    if (d !== EHBR_RST) begin
      failures++; $display("FAIL ehbr_rst: got %h want %h", d, EHBR_RST);
    end
  endtask

  task automatic test_entry();
    logic [31:0] d;
    logic        seen;
    seen = 1'b0;
    @(negedge clk);
    mtc0(5'd15, 32'h100);
    mtc0(5'd12, 32'h0008_0001);
    bus.ir_en    = 1'b1;
    bus.ret_addr = 32'h1234;
    bus.ir_in    = 8'h08;
    #1;
    tests_run++;
    if (bus.jump_en !== 1'b0) begin
      failures++; $display("FAIL entry_early: got %b want 0", bus.jump_en);
    end
    @(negedge clk);
    bus.ir_in = '0;
    #1;
    tests_run++;
    if (bus.jump_en !== 1'b1 || bus.jump_addr !== 32'h100) begin
      failures++;
      $display("FAIL entry_jump: got en=%b addr=%h want en=1 addr=00000100",
               bus.jump_en, bus.jump_addr);
    end
    @(negedge clk);
    rd(5'd14, d);
    tests_run++;
    if (d !== 32'h1234) begin
      failures++; $display("FAIL entry_epc: got %h want 00001234", d);
    end
    rd(5'd13, d);
    tests_run++;
    if (d !== 32'h0300_0000) begin
      failures++; $display("FAIL entry_cause: got %h want 03000000", d);
    end
    rd(5'd12, d);
    tests_run++;
    if (d !== 32'h0008_0003) begin
      failures++; $display("FAIL entry_status: got %h want 00080003", d);
    end
    @(negedge clk);
    pulse_irq(8'h08);
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.jump_en !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL exl_block: got reentry want none");
    end
    mtc0(5'd13, 32'h8);
    bus.oper = 2'b10;
    #1;
    tests_run++;
    if (bus.jump_en !== 1'b1 || bus.jump_addr !== 32'h1234) begin
      failures++;
      $display("FAIL eret_jump: got en=%b addr=%h want en=1 addr=00001234",
               bus.jump_en, bus.jump_addr);
    end
    @(negedge clk);
    bus.oper = 2'b00;
  endtask

  task automatic test_vectored();
    logic [31:0] d;
    mtc0(5'd12, 32'h0024_0005);
    bus.ret_addr = 32'h2000;
    pulse_irq(8'h24);
    #1;
    tests_run++;
    if (bus.jump_en !== 1'b1 || bus.jump_addr !== 32'h120) begin
      failures++;
      $display("FAIL vec_line2: got en=%b addr=%h want en=1 addr=00000120",
               bus.jump_en, bus.jump_addr);
    end
    @(negedge clk);
    bus.oper     = 2'b10;
    bus.ret_addr = 32'h3000;
    #1;
    tests_run++;
    if (bus.jump_en !== 1'b1 || bus.jump_addr !== 32'h2000) begin
      failures++;
      $display("FAIL vec_eret: got en=%b addr=%h want en=1 addr=00002000",
               bus.jump_en, bus.jump_addr);
    end
    @(negedge clk);
    bus.oper = 2'b00;
    #1;
    tests_run++;
    if (bus.jump_en !== 1'b1 || bus.jump_addr !== 32'h150) begin
      failures++;
      $display("FAIL vec_tailchain: got en=%b addr=%h want en=1 addr=00000150",
               bus.jump_en, bus.jump_addr);
    end
    @(negedge clk);
    rd(5'd14, d);
    tests_run++;
    if (d !== 32'h3000) begin
      failures++; $display("FAIL vec_epc: got %h want 00003000", d);
    end
    rd(5'd13, d);
    tests_run++;
    if (d !== 32'h0500_0000) begin
      failures++; $display("FAIL vec_cause: got %h want 05000000", d);
    end
    bus.oper = 2'b10;
    @(negedge clk);
    bus.oper = 2'b00;
  endtask

  task automatic test_timer();
    logic [31:0] d;
    int          hit_at;
    hit_at = -1;
    mtc0(5'd12, 32'h0100_0001);
    mtc0(5'd11, 32'd20);
    bus.ret_addr = 32'h5000;
    mtc0(5'd9, 32'd0);
    for (int k = 0; k <= 40 && hit_at < 0; k++) begin
      #1;
      if (bus.jump_en === 1'b1) begin
        hit_at = k;
        tests_run++;
        if (bus.jump_addr !== 32'h100) begin
          failures++; $display("FAIL timer_addr: got %h want 00000100", bus.jump_addr);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (hit_at != 21) begin
      failures++; $display("FAIL timer_latency: got %0d want 21", hit_at);
    end
    rd(5'd13, d);
    tests_run++;
    if (d !== 32'h0800_0000) begin
      failures++; $display("FAIL timer_cause: got %h want 08000000", d);
    end
    mtc0(5'd9, 32'd100);
    mtc0(5'd11, 32'd101);
    @(negedge clk);
    rd(5'd13, d);
    tests_run++;
    if (d !== 32'h0800_0100) begin
      failures++; $display("FAIL timer_pend: got %h want 08000100", d);
    end
    mtc0(5'd11, 32'd0);
    rd(5'd13, d);
    tests_run++;
    if (d !== 32'h0800_0000) begin
      failures++; $display("FAIL compare_clear: got %h want 08000000", d);
    end
    bus.oper = 2'b10;
    #1;
    tests_run++;
    if (bus.jump_addr !== 32'h5000) begin
      failures++; $display("FAIL timer_eret: got %h want 00005000", bus.jump_addr);
    end
    @(negedge clk);
    bus.oper = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int          pulses;
    pulses   = 0;
    @(negedge clk);
    bus.oper = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus.jump_en === 1'b1) pulses++;
      @(negedge clk);
    end
    bus.oper = 2'b00;
    tests_run++;
    if (pulses != 1) begin
      failures++; $display("FAIL eret_held: got %0d pulses want 1", pulses);
    end
    mtc0(5'd12, 32'h0008_0001);
    bus.ret_addr = 32'h4444;
    pulse_irq(8'h08);
    bus.oper   = 2'b01;
    bus.addr_w = 5'd14;
    bus.data_w = 32'hDEAD;
    bus.addr_r = 5'd9;
    #1;
    tests_run++;
    if (bus.jump_en !== 1'b1 || bus.data_r !== 32'h0) begin
      failures++;
      $display("FAIL store_entry: got en=%b data_r=%h want en=1 data_r=0",
               bus.jump_en, bus.data_r);
    end
    @(negedge clk);
    bus.oper = 2'b00;
    rd(5'd14, d);
    tests_run++;
    if (d !== 32'h4444) begin
      failures++; $display("FAIL epc_drop: got %h want 00004444", d);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    logic        seen;
    seen = 1'b0;
    pulse_irq(8'h02);
    rd(5'd13, d);
    tests_run++;
    if (d !== 32'h0300_0002) begin
      failures++; $display("FAIL pre_rst_cause: got %h want 03000002", d);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd(5'd12, d);
    tests_run++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL rst_status: got %h want 0", d);
    end
    rd(5'd13, d);
    tests_run++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL rst_cause: got %h want 0", d);
    end
    rd(5'd3, d);
    tests_run++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL unmapped: got %h want 0", d);
    end
    @(negedge clk);
    bus.ir_in = 8'h08;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.jump_en !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    bus.ir_in = '0;
    tests_run++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL post_rst_quiet: got jump want none");
    end
  endtask

  initial begin
    bus.oper     = 2'b00;
    bus.addr_r   = 5'd0;
    bus.addr_w   = 5'd0;
    bus.data_w   = 32'h0;
    bus.ir_en    = 1'b0;
    bus.ir_in    = '0;
    bus.ret_addr = 32'h0;
    test_reset();
    test_entry();
    test_vectored();
    test_timer();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
